// File: rtl/pattern_req_scheduler.sv
// pattern_req_scheduler
//   Shares one A/B/C pattern generator among NREQ requesters. A round-robin
//   arbiter picks a requester in IDLE, a single start pulse is issued, the
//   grant is held until the generator finishes, and a guard gap separates
//   consecutive operations.
//
//   Build option: define PRS_TIMEOUT_EN to add the start-to-finish timeout
//   with the sticky o_err flag. Without it, o_err is tied low and the FSM
//   waits indefinitely for the generator.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous reset, active high
//   i_req          level request per requester, held until o_done
//   o_gnt          one-hot grant, held for the whole operation
//   o_done         1-cycle completion pulse to the granted requester
//   o_gen_start    1-cycle start pulse to the generator
//   i_gen_running  generator running flag
//   i_gen_seq      generator phase: 00 idle, 01 A, 10 B, 11 C
//   o_busy         high in any state other than IDLE
//   o_err          sticky timeout flag
//
// state      | meaning
// -----------+-----------------------------------------------------
// S_IDLE     | no operation; arbitrate among pending requests
// S_LAUNCH   | grant set, start pulse to the generator this cycle
// S_WAIT_RUN | waiting for the generator to raise running
// S_WAIT_C   | generator running, waiting for the C phase
// S_WAIT_END | C phase seen, waiting for running to fall
// S_GUARD    | forced idle gap before the next start
module pattern_req_scheduler #(
    parameter int NREQ    = 4,
    parameter int GUARD   = 8,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic [NREQ-1:0] o_done,
    output logic            o_gen_start,
    input  logic            i_gen_running,
    input  logic [1:0]      i_gen_seq,
    output logic            o_busy,
    output logic            o_err
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] C_GUARD_LD = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] C_TMO_LD   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_RUN,
        S_WAIT_C,
        S_WAIT_END,
        S_GUARD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_gidx;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_vld;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_in_op;
    logic             w_end;
    logic             w_tmo;
    logic             w_guard_done;

    // Index of the requester sitting ofs positions above base, wrapping.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base,
                                                 input int ofs);
        int j;
        j = int'(base) + ofs;
        if (j >= NREQ) j = j - NREQ;
        return PTR_W'(j);
    endfunction

    // Scan from the farthest offset down so the nearest set bit at or above
    // the pointer is the one left standing.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[rr_idx(r_ptr, k)]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = rr_idx(r_ptr, k);
            end
        end
    end

    assign w_ptr_nxt    = (r_gidx == PTR_W'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
    assign w_in_op      = (r_state == S_LAUNCH) || (r_state == S_WAIT_RUN) ||
                          (r_state == S_WAIT_C) || (r_state == S_WAIT_END);
    assign w_end        = (r_state == S_WAIT_END) && !i_gen_running;
    assign w_guard_done = (r_state == S_GUARD) && (r_cnt == '0);

`ifdef PRS_TIMEOUT_EN
    // A normal finish on the last allowed cycle wins over the timeout.
    assign w_tmo = w_in_op && !w_end && (r_cnt == '0);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_pick_vld)           w_state_nxt = S_LAUNCH;
            S_LAUNCH:                             w_state_nxt = S_WAIT_RUN;
            S_WAIT_RUN: if (i_gen_running)        w_state_nxt = S_WAIT_C;
            S_WAIT_C:   if (i_gen_seq == 2'b11)   w_state_nxt = S_WAIT_END;
            S_WAIT_END: if (!i_gen_running)       w_state_nxt = S_GUARD;
            S_GUARD:    if (w_guard_done)         w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
        if (w_tmo) w_state_nxt = S_GUARD;
    end

    // One down-counter serves both the timeout (LAUNCH..WAIT_END) and the
    // guard gap; it is reloaded on each phase change.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt  <= '0;
            r_done <= '0;
            r_ptr  <= '0;
            r_gidx <= '0;
            r_cnt  <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_vld) begin
                        r_gnt  <= NREQ'(1) << w_pick_idx;
                        r_gidx <= w_pick_idx;
                        r_cnt  <= C_TMO_LD;
                    end
                end
                S_GUARD: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                default: begin
                    if (w_end) begin
                        r_done <= r_gnt;
                        r_gnt  <= '0;
                        r_ptr  <= w_ptr_nxt;
                        r_cnt  <= C_GUARD_LD;
                    end else if (w_tmo) begin
                        r_gnt  <= '0;
                        r_ptr  <= w_ptr_nxt;
                        r_cnt  <= C_GUARD_LD;
                    end else if (w_in_op && (r_cnt != '0)) begin
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef PRS_TIMEOUT_EN
    logic r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)      r_err <= 1'b0;
        else if (w_tmo) r_err <= 1'b1;
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_gnt       = r_gnt;
    assign o_done      = r_done;
    assign o_gen_start = (r_state == S_LAUNCH);
    assign o_busy      = (r_state != S_IDLE);

endmodule
